// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Results are presented on the DONE edge so the seven-segment path never sees partial digits.
module bcd_seq_converter #(
    parameter int WIDTH = 32,
    parameter int NDIG  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] indt,
    output logic             busy,
    output logic             done,
    output logic [3:0]       dig5,
    output logic [3:0]       dig4,
    output logic [3:0]       dig3,
    output logic [3:0]       dig2,
    output logic [3:0]       dig1,
    output logic [3:0]       dig0,
    output logic [NDIG-1:0]  blank,
    output logic             ovf,
    output logic [1:0]       dbg_state
);
    // Handshake: start is sampled only in IDLE; busy stays high from the accepting
    // edge until the cycle after the one-cycle done pulse; start at any other time is dropped.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * NDIG;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovacc_q, ovacc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BW-1:0]     digits_q, digits_d;
    logic [NDIG-1:0]   blank_q, blank_d;
    logic              ovf_q, ovf_d;
    logic [BW-1:0]     corr;
    logic              zero_run;
    logic [3:0]        dig_arr [6];

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovacc_d  = ovacc_q;
        digits_d = digits_q;
        blank_d  = blank_q;
        ovf_d    = ovf_q;
        busy_d   = (state_q == S_IDLE) ? start : 1'b1;
        done_d   = (state_q == S_DONE);
        zero_run = 1'b1;

        // Each nibble is at most 9 here, so the +3 never carries out of the nibble.
        for (int i = 0; i < NDIG; i++) begin
            corr[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d    = indt;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovacc_d = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d   = {corr[BW-2:0], sr_q[WIDTH-1]};
                sr_d    = sr_q << 1;
                ovacc_d = ovacc_q | corr[BW-1];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                digits_d = acc_q;
                ovf_d    = ovacc_q;
                for (int i = NDIG - 1; i >= 0; i--) begin
                    zero_run   = zero_run & (acc_q[4*i +: 4] == 4'd0);
                    blank_d[i] = zero_run;
                end
                blank_d[0] = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovacc_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
            blank_q  <= {{(NDIG-1){1'b1}}, 1'b0};
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovacc_q  <= ovacc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            dig_arr[i] = 4'd0;
            if (i < NDIG) begin
                dig_arr[i] = digits_q[4*i +: 4];
            end
        end
    end

    assign dig0      = dig_arr[0];
    assign dig1      = dig_arr[1];
    assign dig2      = dig_arr[2];
    assign dig3      = dig_arr[3];
    assign dig4      = dig_arr[4];
    assign dig5      = dig_arr[5];
    assign busy      = busy_q;
    assign done      = done_q;
    assign blank     = blank_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: latency, digit/blank/ovf results,
// back-to-back starts, ignored starts, input stability and mid-conversion reset.
module tb_bcd_seq_converter;
    localparam int WIDTH = 32;
    localparam int NDIG  = 6;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] indt = '0;
    logic             busy, done, ovf;
    logic [3:0]       dig5, dig4, dig3, dig2, dig1, dig0;
    logic [NDIG-1:0]  blank;
    logic [1:0]       dbg_state;

    int checks   = 0;
    int failures = 0;
    // Expected result packed as {1'b0, ovf, blank[5:0], digits[23:0]}
    logic [31:0] exp_q[$];

    bcd_seq_converter #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .indt(indt),
        .busy(busy), .done(done),
        .dig5(dig5), .dig4(dig4), .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
        .blank(blank), .ovf(ovf), .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] digs();
        return {8'h00, dig5, dig4, dig3, dig2, dig1, dig0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic start_conv(input logic [31:0] v, input logic [31:0] expv);
        exp_q.push_back(expv);
        indt  = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic check_result(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_digits"}, digs(), {8'h00, e[23:0]});
            check({tag, "_blank"}, 32'(blank), {26'd0, e[29:24]});
            check({tag, "_ovf"}, 32'(ovf), {31'd0, e[30]});
            check({tag, "_done"}, 32'(done), 32'd1);
            check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] v, input logic [31:0] expv);
        int n;
        start_conv(v, expv);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        wait_done(n);
        check({tag, "_latency"}, n, LAT);
        check_result(tag);
        tick();
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin : main
        int n;
        int done_cnt;

        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_digits", digs(), 32'd0);
        check("rst_blank", 32'(blank), 32'h3e);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick();

        convert("zero",   32'd0,          {1'b0, 1'b0, 6'b111110, 24'h000000});
        convert("n123456", 32'd123456,    {1'b0, 1'b0, 6'b000000, 24'h123456});
        convert("n1e6",   32'd1000000,    {1'b0, 1'b1, 6'b111110, 24'h000000});
        convert("nmax",   32'hFFFFFFFF,   {1'b0, 1'b1, 6'b000000, 24'h967295});

        // back-to-back: 407, then 999999 at the earliest legal edge with stray starts
        start_conv(32'd407, {1'b0, 1'b0, 6'b111000, 24'h000407});
        wait_done(n);
        check("b2b_first_latency", n, LAT);
        check_result("n407");
        start_conv(32'd999999, {1'b0, 1'b0, 6'b000000, 24'h999999});
        check("b2b_busy_held", 32'(busy), 32'd1);
        check("b2b_done_fall", 32'(done), 32'd0);
        done_cnt = 0;
        for (int i = 1; i <= LAT; i++) begin
            start = (i == 5 || i == 12 || i == 20 || i == LAT);
            indt  = 32'd1;
            tick();
            if (done) done_cnt++;
        end
        start = 1'b0;
        check_result("n999999");
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("b2b_one_done", done_cnt, 32'd1);
        check("b2b_idle_after", 32'(busy), 32'd0);

        // indt changes mid-conversion; previous result must hold until done
        start_conv(32'd555555, {1'b0, 1'b0, 6'b000000, 24'h555555});
        for (int i = 1; i < LAT; i++) begin
            tick();
            if (i == 5) indt = 32'd0;
        end
        check("hold_digits", digs(), 32'h999999);
        check("hold_no_done", 32'(done), 32'd0);
        tick();
        check_result("n555555");
        tick();

        // asynchronous reset at shift step 10
        start_conv(32'd777, 32'd0);
        void'(exp_q.pop_back());
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_digits", digs(), 32'd0);
        check("arst_blank", 32'(blank), 32'h3e);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("arst_no_done", done_cnt, 32'd0);
        convert("n42", 32'd42, {1'b0, 1'b0, 6'b111100, 24'h000042});

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
